// File: rtl/ex_mem_skid.sv
// EX/MEM pipeline register with a two-entry skid buffer: MAIN drives the MEM stage,
// SKID absorbs one extra payload so in_ready can be registered.
module ex_mem_skid (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_result,
  input  logic        in_zero,
  input  logic [31:0] in_store,
  input  logic [4:0]  in_rd,
  input  logic [2:0]  in_ctl,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_zero,
  output logic [31:0] out_store,
  output logic [4:0]  out_rd,
  output logic [2:0]  out_ctl,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_data,
  output logic [1:0]  occupancy
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  // Entry layout: {result[31:0], zero, store[31:0], rd[4:0], ctl[2:0]}
  logic [1:0]  r_state;
  logic [1:0]  w_state_d;
  logic [72:0] r_main;
  logic [72:0] r_skid;
  logic [72:0] w_main_d;
  logic [72:0] w_skid_d;
  logic [72:0] w_cap;
  logic [72:0] w_out;
  logic        r_in_ready;
  logic        w_accept;
  logic        w_drain;
  logic        w_out_valid;

  assign w_out_valid = (r_state != ST_EMPTY);
  assign w_accept    = in_valid & r_in_ready;
  assign w_drain     = w_out_valid & out_ready;

  // Writes to $zero are squashed at capture so forwarding never sees them.
  assign w_cap = {in_result, in_zero, in_store, in_rd,
                  in_ctl[2] & (in_rd != 5'd0), in_ctl[1:0]};

  always_comb begin
    w_state_d = r_state;
    w_main_d  = r_main;
    w_skid_d  = r_skid;
    if (flush) begin
      w_state_d = ST_EMPTY;
      w_main_d  = '0;
      w_skid_d  = '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_main_d  = w_cap;
            w_state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_accept && w_drain) begin
            w_main_d = w_cap;
          end else if (w_accept) begin
            w_skid_d  = w_cap;
            w_state_d = ST_FULL;
          end else if (w_drain) begin
            w_main_d  = '0;
            w_state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_drain) begin
            w_main_d  = r_skid;
            w_skid_d  = '0;
            w_state_d = ST_ONE;
          end
        end
        default: begin
          w_state_d = ST_EMPTY;
          w_main_d  = '0;
          w_skid_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_EMPTY;
      r_main     <= '0;
      r_skid     <= '0;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_main     <= w_main_d;
      r_skid     <= w_skid_d;
      r_in_ready <= (w_state_d != ST_FULL);
    end
  end

  assign w_out = w_out_valid ? r_main : '0;

  assign in_ready   = r_in_ready;
  assign out_valid  = w_out_valid;
  assign out_result = w_out[72:41];
  assign out_zero   = w_out[40];
  assign out_store  = w_out[39:8];
  assign out_rd     = w_out[7:3];
  assign out_ctl    = w_out[2:0];
  assign occupancy  = r_state;

  assign fwd_valid = w_out_valid & w_out[2];
  assign fwd_rd    = fwd_valid ? w_out[7:3] : 5'd0;
  assign fwd_data  = fwd_valid ? w_out[72:41] : 32'd0;

endmodule

// File: tb/tb_ex_mem_skid.sv
// Bench for ex_mem_skid: directed vector table, corner sequences, and a random
// stream checked against a queue-based reference model.
module tb_ex_mem_skid;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid, in_ready, in_zero, flush, out_valid, out_ready, out_zero;
  logic [31:0] in_result, in_store, out_result, out_store, fwd_data;
  logic [4:0]  in_rd, out_rd, fwd_rd;
  logic [2:0]  in_ctl, out_ctl;
  logic        fwd_valid;
  logic [1:0]  occupancy;

  localparam logic [31:0] K = 32'h5A5A_5A5A;

  int n_checks = 0;
  int n_fail   = 0;

  ex_mem_skid dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_zero(in_zero), .in_store(in_store), .in_rd(in_rd),
    .in_ctl(in_ctl), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_store(out_store),
    .out_rd(out_rd), .out_ctl(out_ctl), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
    .fwd_data(fwd_data), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv, ordy, fl;
    logic [31:0] res;
    logic [4:0]  rd;
    logic [2:0]  ctl;
    logic        e_ov;
    logic [31:0] e_res;
    logic [4:0]  e_rd;
    logic [2:0]  e_ctl;
    logic [1:0]  e_occ;
    logic        e_ir;
    logic        e_fv;
  } vec_t;

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic [31:0] store;
    logic [4:0]  rd;
    logic [2:0]  ctl;
  } pay_t;

  vec_t tbl[10];
  pay_t q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic ordy, input logic fl,
                       input logic [31:0] res, input logic [4:0] rd, input logic [2:0] ctl);
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    in_result = res;
    in_store  = res ^ K;
    in_zero   = rd[0];
    in_rd     = rd;
    in_ctl    = ctl;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ov"}, out_valid, 0);
    chk({tag, "_occ"}, occupancy, 0);
    chk({tag, "_pay"}, {out_result, out_zero, out_store, out_rd, out_ctl}, 0);
    chk({tag, "_fwd"}, {fwd_valid, fwd_rd, fwd_data}, 0);
  endtask

  initial begin
    pay_t p;
    int pushed, cycles;
    logic iv, ordy, acc, dr;

    tbl[0] = '{1,1,0, 32'h5, 5'd3, 3'b100,  1, 32'h5, 5'd3, 3'b100, 2'd1, 1, 1};
    tbl[1] = '{1,0,0, 32'h11, 5'd4, 3'b110, 1, 32'h5, 5'd3, 3'b100, 2'd2, 0, 1};
    tbl[2] = '{1,0,0, 32'h22, 5'd9, 3'b100, 1, 32'h5, 5'd3, 3'b100, 2'd2, 0, 1};
    tbl[3] = '{0,1,0, 32'h0, 5'd0, 3'b000,  1, 32'h11, 5'd4, 3'b110, 2'd1, 1, 1};
    tbl[4] = '{1,1,0, 32'hFFFF_FFFF, 5'd0, 3'b101, 1, 32'hFFFF_FFFF, 5'd0, 3'b001, 2'd1, 1, 0};
    tbl[5] = '{0,1,0, 32'h0, 5'd0, 3'b000,  0, 32'h0, 5'd0, 3'b000, 2'd0, 1, 0};
    tbl[6] = '{1,0,0, 32'hA5, 5'd7, 3'b010, 1, 32'hA5, 5'd7, 3'b010, 2'd1, 1, 0};
    tbl[7] = '{1,0,0, 32'hB6, 5'd8, 3'b100, 1, 32'hA5, 5'd7, 3'b010, 2'd2, 0, 0};
    tbl[8] = '{1,0,1, 32'hC7, 5'd9, 3'b100, 0, 32'h0, 5'd0, 3'b000, 2'd0, 1, 0};
    tbl[9] = '{0,0,0, 32'h0, 5'd0, 3'b000,  0, 32'h0, 5'd0, 3'b000, 2'd0, 1, 0};

    // Reset state, then release with in_valid already high: nothing is taken.
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #12;
    chk_idle("reset");
    chk("reset_ir", in_ready, 0);
    drive(1, 1, 0, 32'hDEAD, 5'd2, 3'b100);
    #1 reset = 1'b0;
    #1 chk("rel_ir_pre", in_ready, 0);
    step();
    chk("rel_ir_post", in_ready, 1);
    chk("rel_no_accept", occupancy, 0);

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].iv, tbl[i].ordy, tbl[i].fl, tbl[i].res, tbl[i].rd, tbl[i].ctl);
      step();
      chk($sformatf("v%0d_ov", i), out_valid, tbl[i].e_ov);
      chk($sformatf("v%0d_res", i), out_result, tbl[i].e_res);
      chk($sformatf("v%0d_rd", i), out_rd, tbl[i].e_rd);
      chk($sformatf("v%0d_ctl", i), out_ctl, tbl[i].e_ctl);
      chk($sformatf("v%0d_store", i), out_store, tbl[i].e_ov ? (tbl[i].e_res ^ K) : 32'd0);
      chk($sformatf("v%0d_zero", i), out_zero, tbl[i].e_ov ? tbl[i].e_rd[0] : 1'b0);
      chk($sformatf("v%0d_occ", i), occupancy, tbl[i].e_occ);
      chk($sformatf("v%0d_ir", i), in_ready, tbl[i].e_ir);
      chk($sformatf("v%0d_fwd", i), {fwd_valid, fwd_rd, fwd_data},
          {tbl[i].e_fv, tbl[i].e_fv ? tbl[i].e_rd : 5'd0, tbl[i].e_fv ? tbl[i].e_res : 32'd0});
    end

    // Backpressure: A, B fill the buffer; C is held off until room appears.
    drive(1, 0, 0, 32'h11, 5'd1, 3'b100); step();
    drive(1, 0, 0, 32'h22, 5'd2, 3'b100); step();
    chk("bp_occ2", occupancy, 2);
    chk("bp_ir0", in_ready, 0);
    drive(1, 0, 0, 32'h33, 5'd3, 3'b100); step();
    chk("bp_hold_occ", occupancy, 2);
    chk("bp_out_a", out_result, 32'h11);
    drive(1, 1, 0, 32'h33, 5'd3, 3'b100); step();
    chk("bp_out_b", out_result, 32'h22);
    chk("bp_occ_b", occupancy, 1);
    step();
    chk("bp_out_c", out_result, 32'h33);
    chk("bp_occ_c", occupancy, 1);
    drive(0, 1, 0, 0, 0, 0); step();
    chk_idle("bp_end");

    // Asynchronous reset while FULL.
    drive(1, 0, 0, 32'h44, 5'd4, 3'b100); step();
    drive(1, 0, 0, 32'h55, 5'd5, 3'b100); step();
    chk("ar_full", occupancy, 2);
    drive(0, 0, 0, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    chk_idle("ar");
    chk("ar_ir", in_ready, 0);
    #1 reset = 1'b0;
    step();
    chk("ar_ir_post", in_ready, 1);
    chk("ar_occ_post", occupancy, 0);

    // Random stream against a FIFO model bounded at two entries.
    pushed = 0;
    cycles = 0;
    while ((pushed < 1000 || q.size() != 0) && cycles < 20000) begin
      chk("rnd_occ", occupancy, q.size());
      chk("rnd_ir", in_ready, q.size() != 2);
      chk("rnd_inv", in_ready & (occupancy == 2'd2), 0);
      chk("rnd_ov", out_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("rnd_pay", {out_result, out_zero, out_store, out_rd, out_ctl}, q[0]);
        chk("rnd_fwd", {fwd_valid, fwd_rd, fwd_data},
            q[0].ctl[2] ? {1'b1, q[0].rd, q[0].res} : 38'd0);
      end
      iv   = (pushed < 1000) && ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      p.res   = $urandom;
      p.zero  = $urandom_range(0, 1);
      p.store = $urandom;
      p.rd    = $urandom_range(0, 31);
      p.ctl   = $urandom_range(0, 7);
      in_valid  = iv;
      out_ready = ordy;
      flush     = 1'b0;
      in_result = p.res;
      in_zero   = p.zero;
      in_store  = p.store;
      in_rd     = p.rd;
      in_ctl    = p.ctl;
      acc = iv && (q.size() < 2);
      dr  = ordy && (q.size() > 0);
      step();
      cycles++;
      if (dr) void'(q.pop_front());
      if (acc) begin
        if (p.rd == 5'd0) p.ctl[2] = 1'b0;
        q.push_back(p);
        pushed++;
      end
    end
    chk("rnd_done", (pushed == 1000) && (q.size() == 0), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
